mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001: Parameters: none; the datapath width is fixed at 32 bits.
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004: start  input  1  request an operation; sampled only in IDLE.
REQ-005: op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006: a  input  32  operand A (rs value from the register file Read_data1).
REQ-007: b  input  32  operand B (rt value from the register file Read_data2).
REQ-008: hi_we  input  1  MTHI write strobe.
REQ-009: lo_we  input  1  MTLO write strobe.
REQ-010: wdata  input  32  data for MTHI/MTLO.
REQ-011: busy  output  1  operation in progress; HI/LO not valid.
REQ-012: done  output  1  one-cycle pulse: HI/LO hold the new result.
REQ-013: hi  output  32  HI register (product[63:32] or remainder).
REQ-014: lo  output  32  LO register (product[31:0] or quotient).
REQ-015: div_by_zero  output  1  the last completed divide had b==0; valid while done=1 and held until the next start.

Function
REQ-016: FSM states: IDLE, CALC, FIXUP.
- IDLE->CALC on start.
- CALC->FIXUP after the 32nd iteration.
- FIXUP->IDLE unconditionally.
REQ-017: Edge 1 (start sampled in IDLE): operands latched, sign flags captured, |a| and |b| formed for signed ops, iteration count cleared, busy=1.
REQ-018: Edges 2-33: one iteration per edge.
- Multiply: shift-add on a 64-bit accumulator.
- Divide: restoring shift-subtract, 1 quotient bit per edge.
REQ-019: Edge 34 (FIXUP): sign correction applied, hi/lo written, done=1 for exactly one cycle, busy=0, state returns to IDLE; latency is 34 cycles from the start edge to done.
REQ-020: Signed multiply: the 64-bit product is negated when sign(a) differs from sign(b).
REQ-021: Signed divide sign rules:
- Quotient is negated when sign(a) differs from sign(b).
- Remainder takes the sign of a.
- Truncation is toward zero.
REQ-022: Division by zero:
- Still runs the full 34 cycles.
- Result: lo=32'hFFFFFFFF, hi=a unmodified.
- div_by_zero=1.
REQ-023: DIV of 32'h80000000 by 32'hFFFFFFFF gives lo=32'h80000000, hi=0, div_by_zero=0, with no trap.
REQ-024: start while busy=1 is ignored: no effect on state or operands.
REQ-025: start in the cycle done=1 is accepted, since the FSM is already in IDLE.
REQ-026: hi_we/lo_we are honoured only in IDLE with start=0.
- They write wdata on that edge, and both strobes may act together.
- They are dropped while busy or when start=1 in the same cycle.
REQ-027: hi/lo hold their values while busy; intermediate values never appear on hi/lo.
REQ-028: a, b and op are don't-care after the start edge.

Reset
REQ-029: rst_n=0 immediately forces: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, iteration count=0.
REQ-030: Reset during CALC or FIXUP aborts the operation; no done pulse is produced for it.
REQ-031: Operation resumes on the first rising clk edge after rst_n deasserts.

Structure
REQ-032: The shared package mdu_pkg holds:
- the op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
- the state enum;
- the iteration constant MDU_ITERS=32.
REQ-033: One sub-module, mdu_sign_fix: combinational 64-bit conditional negation used at both operand entry and FIXUP.
REQ-034: A single shared 64-bit accumulator and a 6-bit iteration counter serve both multiply and divide.

Verification
REQ-035: MULT a=32'hFFFFFFFD (-3), b=5 -> done on cycle 34; hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
REQ-036: MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-037: DIV a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-038: DIVU a=100, b=0 -> lo=32'hFFFFFFFF, hi=32'h00000064, div_by_zero=1.
REQ-039: Abort and lockout checks:
- A second start asserted 5 cycles into an operation is ignored; the result is unchanged and only one done pulse appears.
- rst_n pulsed low at cycle 10 of a MULT gives busy=0 and hi=lo=0 with no done pulse.
REQ-040: MTHI wdata=32'h12345678 with start=1 in the same cycle -> the write is dropped and the operation proceeds; repeated with start=0 in IDLE, hi=32'h12345678 on the next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared definitions for the multiply/divide unit: operation
//                encodings, FSM state type and iteration count.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int MDU_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } mdu_state_t;

    // Signed variants treat operands as two's complement
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // Divide variants use the restoring shift-subtract datapath
    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_sign_fix.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_sign_fix
//  Description : 64-bit conditional two's-complement negation. Used to form
//                operand magnitudes on entry and to restore result signs.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_sign_fix (
    input  logic [63:0] din,
    input  logic        neg,
    output logic [63:0] dout
);

    assign dout = neg ? (64'd0 - din) : din;

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative 32x32 multiply / 32/32 divide unit with HI/LO
//                result registers. One bit per clock over 32 iterations on a
//                shared 64-bit accumulator, bracketed by an operand-entry
//                edge and a sign-fixup edge (34 cycles start to done).
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    localparam logic [5:0] c_last_iter = 6'(MDU_ITERS - 1);

    mdu_state_t  r_state;
    logic [63:0] r_acc;       // multiply: {partial, multiplier}; divide: {remainder, quotient}
    logic [31:0] r_opb;       // |b|: multiplicand or divisor
    logic [31:0] r_a_raw;     // original a, returned in HI on divide-by-zero
    logic [5:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_res;   // product / quotient needs negation
    logic        r_neg_rem;   // remainder needs negation (follows sign of a)
    logic        r_b_zero;
    logic        r_busy;
    logic        r_done;
    logic        r_dbz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_signed;
    logic [63:0] w_abs_a;
    logic [63:0] w_abs_b;
    logic        w_b_zero;
    logic [32:0] w_mul_add;
    logic [63:0] w_mul_next;
    logic [33:0] w_div_sub;
    logic [63:0] w_div_next;
    logic [63:0] w_fix_prod;
    logic [63:0] w_fix_rem;
    logic        w_unused_bits;

    assign w_signed = op_is_signed(op);

    // Magnitudes: sign-extend signed operands so the negated value is a
    // clean zero-extended |x| across all 64 bits.
    mdu_sign_fix u_abs_a (
        .din  (w_signed ? {{32{a[31]}}, a} : {32'd0, a}),
        .neg  (w_signed & a[31]),
        .dout (w_abs_a)
    );

    mdu_sign_fix u_abs_b (
        .din  (w_signed ? {{32{b[31]}}, b} : {32'd0, b}),
        .neg  (w_signed & b[31]),
        .dout (w_abs_b)
    );

    assign w_b_zero = (w_abs_b == 64'd0);

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign w_mul_add  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
    assign w_mul_next = {w_mul_add, r_acc[31:1]};

    // Restoring divide step: trial-subtract divisor from the shifted partial
    // remainder; keep the difference and shift in a 1 when it does not borrow.
    assign w_div_sub  = {1'b0, r_acc[63:31]} - {2'b00, r_opb};
    assign w_div_next = w_div_sub[33] ? {r_acc[62:0], 1'b0}
                                      : {w_div_sub[31:0], r_acc[30:0], 1'b1};

    // Full 64-bit negation covers the product; its low half is also the
    // negated quotient since low bits of a negation depend only on low bits.
    mdu_sign_fix u_fix_prod (
        .din  (r_acc),
        .neg  (r_neg_res),
        .dout (w_fix_prod)
    );

    mdu_sign_fix u_fix_rem (
        .din  ({32'd0, r_acc[63:32]}),
        .neg  (r_neg_rem),
        .dout (w_fix_rem)
    );

    // Bits that are structurally present but carry no information
    assign w_unused_bits = ^{w_fix_rem[63:32], w_div_sub[32]};

    // Control FSM, iterative datapath and HI/LO result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_acc     <= 64'd0;
            r_opb     <= 32'd0;
            r_a_raw   <= 32'd0;
            r_cnt     <= 6'd0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc     <= w_abs_a;
                        r_opb     <= w_abs_b[31:0];
                        r_a_raw   <= a;
                        r_is_div  <= op_is_div(op);
                        r_neg_res <= w_signed & (a[31] ^ b[31]);
                        r_neg_rem <= w_signed & a[31];
                        r_b_zero  <= w_b_zero;
                        r_cnt     <= 6'd0;
                        r_busy    <= 1'b1;
                        r_dbz     <= 1'b0;
                        r_state   <= ST_CALC;
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                ST_CALC: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_last_iter) begin
                        r_state <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    if (r_is_div) begin
                        if (r_b_zero) begin
                            r_hi <= r_a_raw;
                            r_lo <= 32'hFFFF_FFFF;
                        end else begin
                            r_hi <= w_fix_rem[31:0];
                            r_lo <= w_fix_prod[31:0];
                        end
                    end else begin
                        r_hi <= w_fix_prod[63:32];
                        r_lo <= w_fix_prod[31:0];
                    end
                    r_dbz   <= r_is_div & r_b_zero;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Scoreboard bench for mult_div_unit. The driver pushes the
//                hand-computed result of each accepted operation; a monitor
//                pops and compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          scyc;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    mult_div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive one accepted operation and record its expected result
    task automatic issue(input int id, input logic [1:0] o, input logic [31:0] xa,
                         input logic [31:0] xb, input logic [31:0] eh,
                         input logic [31:0] el, input logic ed);
        exp_t e;
        e.hi = eh; e.lo = el; e.dbz = ed; e.scyc = cyc + 1; e.id = id;
        sb_q.push_back(e);
        op = o; a = xa; b = xb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom);
        a  = $urandom;
        b  = $urandom;
    endtask

    task automatic wait_done(input int id);
        int k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("op%0d_done_seen", id), {31'd0, done}, 32'd1);
    endtask

    // Monitor: compare every done pulse against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1, expected no pending operation (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("op%0d_hi", e.id), hi, e.hi);
                    check($sformatf("op%0d_lo", e.id), lo, e.lo);
                    check($sformatf("op%0d_dbz", e.id), {31'd0, div_by_zero}, {31'd0, e.dbz});
                    check($sformatf("op%0d_latency", e.id), 32'(cyc - e.scyc + 1), 32'd34);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
        check("rst_hi",   hi, 32'd0);
        check("rst_lo",   lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back chain: each new start lands in the previous done cycle
        issue(1, OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        wait_done(1);
        issue(2, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_done(2);
        issue(3, OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done(3);
        issue(4, OP_DIVU,  32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        wait_done(4);
        @(negedge clk);
        check("dbz_held", {31'd0, div_by_zero}, 32'd1);
        check("done_one_cycle", {31'd0, done}, 32'd0);

        issue(5,  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        wait_done(5);
        issue(6,  OP_DIV,   32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1);
        wait_done(6);
        issue(7,  OP_MULT,  32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
        wait_done(7);
        issue(8,  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        wait_done(8);
        issue(9,  OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0);
        wait_done(9);
        issue(10, OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0);
        wait_done(10);
        @(negedge clk);

        // Lockout: a second start mid-operation is ignored, HI/LO hold
        issue(11, OP_MULTU, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 1'b0);
        repeat (4) @(negedge clk);
        op = OP_DIVU; a = 32'd9; b = 32'd3; start = 1'b1;
        check("lock_busy", {31'd0, busy}, 32'd1);
        check("lock_hi_hold", hi, 32'h0000_0001);
        check("lock_lo_hold", lo, 32'h0000_0000);
        @(negedge clk);
        start = 1'b0;
        wait_done(11);
        repeat (5) @(negedge clk);

        // MTHI with start in the same cycle is dropped
        hi_we = 1'b1; wdata = 32'h1234_5678;
        issue(12, OP_MULTU, 32'd2, 32'd3, 32'h0000_0000, 32'h0000_0006, 1'b0);
        hi_we = 1'b0;
        wait_done(12);
        @(negedge clk);
        // MTHI + MTLO together in IDLE
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi_idle", hi, 32'h1234_5678);
        check("mtlo_idle", lo, 32'h1234_5678);

        // Strobes while busy are dropped
        issue(13, OP_MULTU, 32'd1, 32'd1, 32'h0000_0000, 32'h0000_0001, 1'b0);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi_busy_drop", hi, 32'h1234_5678);
        check("mtlo_busy_drop", lo, 32'h1234_5678);
        wait_done(13);
        @(negedge clk);

        // Abort by reset 10 cycles into a MULT (no scoreboard entry)
        op = OP_MULT; a = 32'd5; b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Operation resumes normally after reset
        issue(14, OP_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0);
        wait_done(14);
        repeat (3) @(negedge clk);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
